// File: rtl/mx_pe_v2.sv
// Systolic MX processing element: decodes FP8 (E4M3/E5M2) pairs, accumulates aligned
// products in a saturating fixed-point register and emits a block-scaled BF16 result.
module mx_pe_v2 #(
    parameter int ACC_W = 32,
    parameter int FRAC  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clear,
    input  logic        fmt,
    input  logic        in_valid,
    input  logic        in_last,
    input  logic [7:0]  a_in,
    input  logic [7:0]  b_in,
    input  logic [7:0]  scale_a,
    input  logic [7:0]  scale_b,
    output logic [7:0]  a_out,
    output logic [7:0]  b_out,
    output logic        valid_out,
    output logic        last_out,
    output logic [15:0] c_out,
    output logic        c_valid,
    output logic [1:0]  c_flags
);
    // Framing: no back-pressure. A pair is accepted on any edge with in_valid high and
    // clear low; in_last only counts when in_valid is high. c_valid is a one-cycle pulse.
    localparam logic [ACC_W-1:0]        MAX  = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   MAXS = {2'b00, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W:0]   MINS = -MAXS;

    function automatic void fp8_decode(input logic [7:0] x, input logic f,
                                       output logic [3:0] sig, output logic signed [6:0] ue,
                                       output logic nan);
        if (!f) begin
            nan = (x[6:0] == 7'h7f);
            sig = {(x[6:3] != 4'd0), x[2:0]};
            ue  = (x[6:3] == 4'd0) ? -7'sd6 : $signed({3'b000, x[6:3]}) - 7'sd7;
        end else begin
            nan = (x[6:2] == 5'h1f);
            sig = {(x[6:2] != 5'd0), x[1:0], 1'b0};
            ue  = (x[6:2] == 5'd0) ? -7'sd14 : $signed({2'b00, x[6:2]}) - 7'sd15;
        end
    endfunction

    // pass-through
    logic [7:0] a_out_q, a_out_d, b_out_q, b_out_d;
    logic       valid_out_q, valid_out_d, last_out_q, last_out_d;
    // stage 0: decode
    logic [3:0]        sig_a_q, sig_a_d, sig_b_q, sig_b_d;
    logic signed [6:0] esum_q, esum_d;
    logic              sgn0_q, sgn0_d, nan0_q, nan0_d, v0_q, v0_d, l0_q, l0_d;
    logic [7:0]        sa0_q, sa0_d, sb0_q, sb0_d;
    // stage 1: aligned magnitude
    logic [ACC_W-1:0]  mag1_q, mag1_d;
    logic              neg1_q, neg1_d, sat1_q, sat1_d, nan1_q, nan1_d, v1_q, v1_d, l1_q, l1_d;
    logic [7:0]        sa1_q, sa1_d, sb1_q, sb1_d;
    // stage 2: accumulator
    logic [ACC_W-1:0]  acc_q, acc_d;
    logic              busy_q, busy_d, bnan_q, bnan_d, bsat_q, bsat_d, done2_q, done2_d;
    logic [7:0]        sa2_q, sa2_d, sb2_q, sb2_d;
    // stage 3: result
    logic [15:0]       c_q, c_d;
    logic [1:0]        flags_q, flags_d;
    logic              cv_q, cv_d;

    logic [3:0]          da_sig, db_sig;
    logic signed [6:0]   da_ue, db_ue;
    logic                da_nan, db_nan;
    logic [7:0]          prod;
    int                  sh, p, e_i;
    logic [ACC_W+7:0]    wide, shl;
    logic                ovf, nan_any;
    logic signed [ACC_W:0] base, addend, sum;
    logic [ACC_W-1:0]    cmag, norm;

    always_comb begin
        a_out_d     = a_in;
        b_out_d     = b_in;
        valid_out_d = in_valid;
        last_out_d  = in_last;

        fp8_decode(a_in, fmt, da_sig, da_ue, da_nan);
        fp8_decode(b_in, fmt, db_sig, db_ue, db_nan);
        sig_a_d = da_sig;
        sig_b_d = db_sig;
        esum_d  = da_ue + db_ue;
        sgn0_d  = a_in[7] ^ b_in[7];
        nan0_d  = da_nan | db_nan;
        v0_d    = in_valid & ~clear;
        l0_d    = in_valid & in_last;
        sa0_d   = scale_a;
        sb0_d   = scale_b;

        // product value is prod * 2^(esum-6); align it to FRAC fraction bits
        prod = nan0_q ? 8'd0 : 8'(sig_a_q) * 8'(sig_b_q);
        sh   = int'(esum_q) + FRAC - 6;
        wide = {{ACC_W{1'b0}}, prod};
        ovf  = 1'b0;
        if (sh >= 0) begin
            shl = wide << sh;
            ovf = ((sh >= ACC_W - 1) && (prod != 8'd0)) || (shl > {8'd0, MAX});
        end else begin
            shl = wide >> (-sh);
        end
        mag1_d = ovf ? MAX : shl[ACC_W-1:0];
        neg1_d = sgn0_q;
        sat1_d = ovf;
        nan1_d = nan0_q;
        v1_d   = v0_q & ~clear;
        l1_d   = l0_q;
        sa1_d  = sa0_q;
        sb1_d  = sb0_q;

        base   = busy_q ? $signed({acc_q[ACC_W-1], acc_q}) : '0;
        addend = neg1_q ? -$signed({1'b0, mag1_q}) : $signed({1'b0, mag1_q});
        sum    = base + addend;
        acc_d   = acc_q;
        busy_d  = busy_q;
        bnan_d  = bnan_q;
        bsat_d  = bsat_q;
        done2_d = 1'b0;
        sa2_d   = sa2_q;
        sb2_d   = sb2_q;
        if (clear) begin
            acc_d  = '0;
            busy_d = 1'b0;
            bnan_d = 1'b0;
            bsat_d = 1'b0;
        end else if (v1_q) begin
            bnan_d = (busy_q & bnan_q) | nan1_q;
            bsat_d = (busy_q & bsat_q) | sat1_q;
            if (sum > MAXS) begin
                acc_d  = MAXS[ACC_W-1:0];
                bsat_d = 1'b1;
            end else if (sum < MINS) begin
                acc_d  = MINS[ACC_W-1:0];
                bsat_d = 1'b1;
            end else begin
                acc_d = sum[ACC_W-1:0];
            end
            busy_d  = ~l1_q;
            done2_d = l1_q;
            sa2_d   = sa1_q;
            sb2_d   = sb1_q;
        end

        // BF16 conversion of the finished block, mantissa truncated toward zero
        cmag = acc_q[ACC_W-1] ? -acc_q : acc_q;
        p    = 0;
        for (int i = 0; i < ACC_W; i++) begin
            if (cmag[i]) p = i;
        end
        e_i     = p - FRAC + 127 + int'(sa2_q) + int'(sb2_q) - 254;
        norm    = cmag << (ACC_W - 1 - p);
        nan_any = bnan_q | (sa2_q == 8'hff) | (sb2_q == 8'hff);
        c_d     = c_q;
        flags_d = flags_q;
        cv_d    = 1'b0;
        if (done2_q && !clear) begin
            cv_d    = 1'b1;
            flags_d = {nan_any, bsat_q};
            if (nan_any)                c_d = 16'h7fc0;
            else if (acc_q == '0)       c_d = 16'h0000;
            else if (e_i >= 255)        c_d = {acc_q[ACC_W-1], 15'h7f80};
            else if (e_i <= 0)          c_d = {acc_q[ACC_W-1], 15'h0000};
            else                        c_d = {acc_q[ACC_W-1], e_i[7:0], norm[ACC_W-2 -: 7]};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_out_q <= '0; b_out_q <= '0; valid_out_q <= 1'b0; last_out_q <= 1'b0;
            sig_a_q <= '0; sig_b_q <= '0; esum_q <= '0; sgn0_q <= 1'b0; nan0_q <= 1'b0;
            v0_q <= 1'b0; l0_q <= 1'b0; sa0_q <= '0; sb0_q <= '0;
            mag1_q <= '0; neg1_q <= 1'b0; sat1_q <= 1'b0; nan1_q <= 1'b0;
            v1_q <= 1'b0; l1_q <= 1'b0; sa1_q <= '0; sb1_q <= '0;
            acc_q <= '0; busy_q <= 1'b0; bnan_q <= 1'b0; bsat_q <= 1'b0; done2_q <= 1'b0;
            sa2_q <= '0; sb2_q <= '0;
            c_q <= '0; flags_q <= '0; cv_q <= 1'b0;
        end else begin
            a_out_q <= a_out_d; b_out_q <= b_out_d; valid_out_q <= valid_out_d; last_out_q <= last_out_d;
            sig_a_q <= sig_a_d; sig_b_q <= sig_b_d; esum_q <= esum_d; sgn0_q <= sgn0_d; nan0_q <= nan0_d;
            v0_q <= v0_d; l0_q <= l0_d; sa0_q <= sa0_d; sb0_q <= sb0_d;
            mag1_q <= mag1_d; neg1_q <= neg1_d; sat1_q <= sat1_d; nan1_q <= nan1_d;
            v1_q <= v1_d; l1_q <= l1_d; sa1_q <= sa1_d; sb1_q <= sb1_d;
            acc_q <= acc_d; busy_q <= busy_d; bnan_q <= bnan_d; bsat_q <= bsat_d; done2_q <= done2_d;
            sa2_q <= sa2_d; sb2_q <= sb2_d;
            c_q <= c_d; flags_q <= flags_d; cv_q <= cv_d;
        end
    end

    assign a_out     = a_out_q;
    assign b_out     = b_out_q;
    assign valid_out = valid_out_q;
    assign last_out  = last_out_q;
    assign c_out     = c_q;
    assign c_valid   = cv_q;
    assign c_flags   = flags_q;
endmodule

// File: tb/tb_mx_pe_v2.sv
// Directed bench for mx_pe_v2: hand-computed BF16 results, latency, flags and framing.
module tb_mx_pe_v2;
  logic        clk, rst, clear, fmt, in_valid, in_last;
  logic [7:0]  a_in, b_in, scale_a, scale_b, a_out, b_out;
  logic        valid_out, last_out, c_valid;
  logic [15:0] c_out;
  logic [1:0]  c_flags;
  int          n_checks, n_errors;

  mx_pe_v2 #(.ACC_W(32), .FRAC(16)) dut (
    .clk(clk), .rst(rst), .clear(clear), .fmt(fmt), .in_valid(in_valid), .in_last(in_last),
    .a_in(a_in), .b_in(b_in), .scale_a(scale_a), .scale_b(scale_b),
    .a_out(a_out), .b_out(b_out), .valid_out(valid_out), .last_out(last_out),
    .c_out(c_out), .c_valid(c_valid), .c_flags(c_flags)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic drive_pair(input logic [7:0] a, input logic [7:0] b, input logic last,
                            input logic [7:0] sa, input logic [7:0] sb);
    in_valid = 1'b1; in_last = last; a_in = a; b_in = b; scale_a = sa; scale_b = sb;
    @(posedge clk); #1;
  endtask

  task automatic wait_result(input string tag, input logic [15:0] exp_c, input logic [1:0] exp_f);
    int lat;
    lat = 0;
    in_valid = 1'b0; in_last = 1'b0;
    for (int i = 1; i <= 8 && lat == 0; i++) begin
      @(posedge clk); #1;
      if (c_valid) lat = i;
    end
    check({tag, "_latency"}, lat, 3);
    check({tag, "_c_out"}, c_out, exp_c);
    check({tag, "_flags"}, c_flags, exp_f);
    @(posedge clk); #1;
    check({tag, "_pulse"}, c_valid, 0);
  endtask

  initial begin
    int hits;
    n_checks = 0; n_errors = 0;
    rst = 1'b1; clear = 1'b0; fmt = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    a_in = '0; b_in = '0; scale_a = '0; scale_b = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_c_out", c_out, 0);
    check("rst_c_valid", c_valid, 0);
    check("rst_flags", c_flags, 0);
    check("rst_pass", {a_out, b_out, valid_out, last_out}, 0);
    rst = 1'b0;

    // 1.0*2.0 + 1.5*1.5 = 4.25
    drive_pair(8'h38, 8'h40, 1'b0, 8'd127, 8'd127);
    drive_pair(8'h3c, 8'h3c, 1'b1, 8'd127, 8'd127);
    wait_result("basic", 16'h4088, 2'b00);

    // scale_a one higher doubles the result
    drive_pair(8'h38, 8'h40, 1'b0, 8'd128, 8'd127);
    drive_pair(8'h3c, 8'h3c, 1'b1, 8'd128, 8'd127);
    wait_result("scaled", 16'h4108, 2'b00);

    // E5M2: 1.0 * -2.0
    fmt = 1'b1;
    drive_pair(8'h3c, 8'hc0, 1'b1, 8'd127, 8'd127);
    wait_result("e5m2", 16'hc000, 2'b00);
    fmt = 1'b0;

    drive_pair(8'h7f, 8'h38, 1'b0, 8'd127, 8'd127);
    drive_pair(8'h38, 8'h38, 1'b1, 8'd127, 8'd127);
    wait_result("nan_blk", 16'h7fc0, 2'b10);
    drive_pair(8'h38, 8'h38, 1'b1, 8'd127, 8'd127);
    wait_result("after_nan", 16'h3f80, 2'b00);

    drive_pair(8'h38, 8'h38, 1'b1, 8'hff, 8'd127);
    wait_result("scale_nan", 16'h7fc0, 2'b10);

    // 448*448 exceeds the Q15.16 range
    drive_pair(8'h7e, 8'h7e, 1'b1, 8'd127, 8'd127);
    wait_result("sat", 16'h46ff, 2'b01);

    // back-to-back single-pair blocks: 2.0 then 2.25
    drive_pair(8'h38, 8'h40, 1'b1, 8'd127, 8'd127);
    check("pass_a", a_out, 8'h38);
    check("pass_b", b_out, 8'h40);
    check("pass_vl", {valid_out, last_out}, 2'b11);
    drive_pair(8'h3c, 8'h3c, 1'b1, 8'd127, 8'd127);
    check("pass_a2", a_out, 8'h3c);
    in_valid = 1'b0; in_last = 1'b0;
    @(posedge clk); #1;
    check("b2b_n2", c_valid, 0);
    check("pass_v0", valid_out, 0);
    @(posedge clk); #1;
    check("b2b_v1", c_valid, 1);
    check("b2b_c1", c_out, 16'h4000);
    @(posedge clk); #1;
    check("b2b_v2", c_valid, 1);
    check("b2b_c2", c_out, 16'h4010);
    @(posedge clk); #1;
    check("b2b_end", c_valid, 0);

    // clear one cycle after a last pair aborts the block
    drive_pair(8'h3c, 8'h3c, 1'b1, 8'd127, 8'd127);
    in_valid = 1'b0; in_last = 1'b0; clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    hits = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (c_valid) hits++;
    end
    check("clear_no_cv", hits, 0);
    check("clear_hold", c_out, 16'h4010);
    drive_pair(8'h38, 8'h38, 1'b1, 8'd127, 8'd127);
    wait_result("after_clear", 16'h3f80, 2'b00);

    // reset in the middle of a block
    drive_pair(8'h3c, 8'h3c, 1'b0, 8'd127, 8'd127);
    in_valid = 1'b0; rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("midrst_c", {c_out, c_flags, c_valid}, 0);
    check("midrst_pass", {a_out, b_out, valid_out, last_out}, 0);
    drive_pair(8'h38, 8'h40, 1'b0, 8'd127, 8'd127);
    drive_pair(8'h3c, 8'h3c, 1'b1, 8'd127, 8'd127);
    wait_result("after_rst", 16'h4088, 2'b00);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
